mmio_io_ctrl: RTL and testbench
===============================

# mmio_io_ctrl

Memory-mapped I/O controller between the CPU memory/writeback stage and the on-chip UART. It replaces direct single-byte UART access with parametrised RX/TX FIFOs, sticky error flags and performance counters (cycles, retired instructions, branches, correct predictions). Loads and stores whose address has addr[31:28] == 4'h8 are routed here. Load data is returned with the same one-cycle registered latency as BIOS and DMEM reads.

## Interface
- DEPTH, 8, FIFO depth per direction; power of two, 2..128
- CNT_WIDTH, 32, performance-counter width, 1..32; zero-extended on read
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- addr  in  32  load/store address from the execute stage
- re  in  1  load strobe, qualified internally by addr[31:28] == 4'h8
- we  in  1  store strobe, qualified the same way
- wdata  in  32  store data; only [7:0] is used by the TX register
- rdata  out  32  registered load data, valid the cycle after re
- inst_retire  in  1  one instruction retired this cycle
- br_retire  in  1  one branch retired this cycle
- br_correct  in  1  the retired branch was predicted correctly; only counted when br_retire = 1
- rx_data  in  8  UART receiver byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  RX FIFO can accept a byte
- tx_data  out  8  byte offered to the UART transmitter
- tx_valid  out  1  TX FIFO is non-empty
- tx_ready  in  1  transmitter accepts tx_data

## Operation
Address map (offset = addr[5:0]; all other in-window offsets read 0 and ignore stores):
- 0x00 status (read):
  - bit0 = TX FIFO not full
  - bit1 = RX FIFO not empty
  - [15:8] = RX occupancy
  - [23:16] = TX occupancy
- 0x04 RX data (read): pops the head byte and returns it zero-extended. If the FIFO is empty, returns 0 and sets the rx_underflow flag.
- 0x08 TX data (write): pushes wdata[7:0]. If the FIFO is full, the byte is dropped and the tx_overflow flag is set.
- 0x0C flags:
  - read: bit0 = tx_overflow, bit1 = rx_underflow
  - write of any value clears both flags
- 0x10 cycle count, 0x14 instruction count, 0x18 branch count, 0x1C correct-branch count (all read-only).
- 0x20 (write): clears all four counters.

FIFOs:
- Circular buffer with log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH.
- Occupancy count is log2(DEPTH)+1 bits.
- full = (count == DEPTH); empty = (count == 0). Both are computed from registered state.
- rx_ready = !RX full. An RX push occurs on rx_valid && rx_ready.
- tx_valid = !TX empty; tx_data = TX head. A TX pop occurs on tx_valid && tx_ready.
- A simultaneous push and pop on one FIFO leaves count unchanged and advances both pointers.
- A push while full is refused even if a pop occurs in the same cycle.

Counters:
- cycle increments every cycle.
- instruction count increments on inst_retire.
- branch count increments on br_retire.
- correct-branch count increments on br_retire && br_correct.
- All counters wrap modulo 2^CNT_WIDTH.
- A clear via offset 0x20 takes priority over increments in the same cycle: every counter reads 0 the next cycle.

re and we asserted together: the store is performed and rdata is 0.

## Timing
- Reset values:
  - rdata = 0
  - FIFOs empty: rx_ready = 1, tx_valid = 0, tx_data = 0
  - all counters and flags = 0
- Load latency: 1 cycle. rdata is captured at the clock edge where re is high and holds until the next load.
- rdata reflects state before that edge's updates. Counter reads return the pre-increment value; the status register read in the same cycle as a push does not include that push.
- An RX pop and its data capture happen at the same edge.
- Pushes and pops are visible in status one cycle later.
- rx_valid-to-readable: 1 cycle. Store-to-tx_valid: 1 cycle.
- A flag set and a flag-clear store in the same cycle: the set wins.
- Reset mid-transfer: FIFO contents are discarded and pointers return to 0; the UART handshake restarts cleanly.

## Test plan
- Reset, then read 0x00 -> rdata = 0x0000_0001; tx_valid = 0; rx_ready = 1.
- With tx_ready = 0, store 0x41..0x48 (DEPTH = 8), then a ninth store 0x49 -> status[23:16] = 8 and bit0 = 0; 0x0C reads 1; after raising tx_ready, tx_data sequence is 0x41..0x48 and 0x49 never appears.
- Push 8 RX bytes 0x10..0x17 -> rx_ready = 0. Loading 0x04 eight times returns 0x10..0x17. A ninth load returns 0 and 0x0C reads 2.
- Keep RX at count 3 with a push and a pop in the same cycle -> count stays 3 and byte order is preserved across pointer wrap.
- Counters: 10 cycles with inst_retire = 1, 4 br_retire pulses of which 3 have br_correct = 1, then read 0x14/0x18/0x1C -> 10/4/3. Store to 0x20 while inst_retire = 1 -> a read the next cycle returns 0. With CNT_WIDTH = 4, the cycle count wraps 15 -> 0.
- Assert rst mid-stream with 5 TX bytes queued -> the next cycle tx_valid = 0, status = 0x0000_0001, and the flags are 0.

Source files
------------

// File: rtl/mmio_io_ctrl_if.sv
// CPU-side memory-mapped bus for mmio_io_ctrl.
//   addr  : load/store address from the execute stage
//   re    : load strobe
//   we    : store strobe
//   wdata : store data
//   rdata : registered load data, valid the cycle after re
// The master modport is the CPU side; the slave modport is the controller.
interface mmio_io_ctrl_if;
  logic [31:0] addr;
  logic        re;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, re, we, wdata, input rdata);
  modport slave  (input addr, re, we, wdata, output rdata);
endinterface

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller between the CPU memory/writeback stage and
// the on-chip UART: RX/TX byte FIFOs, sticky error flags and performance
// counters, all reachable in the addr[31:28] == 4'h8 window.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus           : CPU load/store bus (slave side)
//   inst_retire   : one instruction retired this cycle
//   br_retire     : one branch retired this cycle
//   br_correct    : retired branch was predicted correctly
//   rx_data/valid : byte from the UART receiver, rx_ready = RX FIFO not full
//   tx_data/valid : byte offered to the UART transmitter, popped on tx_ready
//
// Register map (offset = addr[5:0]):
//   0x00 R status  {8'h0, tx_count, rx_count, 6'h0, rx_not_empty, tx_not_full}
//   0x04 R RX data (pops; empty read returns 0 and sets rx_underflow)
//   0x08 W TX data (full store drops the byte and sets tx_overflow)
//   0x0C R flags {rx_underflow, tx_overflow}; W clears both
//   0x10/0x14/0x18/0x1C R cycle/instruction/branch/correct-branch counters
//   0x20 W clear all counters
module mmio_io_ctrl #(
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mmio_io_ctrl_if.slave        bus,
  input  logic                 inst_retire,
  input  logic                 br_retire,
  input  logic                 br_correct,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [5:0] OFF_STATUS = 6'h00;
  localparam logic [5:0] OFF_RX     = 6'h04;
  localparam logic [5:0] OFF_TX     = 6'h08;
  localparam logic [5:0] OFF_FLAGS  = 6'h0C;
  localparam logic [5:0] OFF_CYC    = 6'h10;
  localparam logic [5:0] OFF_INST   = 6'h14;
  localparam logic [5:0] OFF_BR     = 6'h18;
  localparam logic [5:0] OFF_BRC    = 6'h1C;
  localparam logic [5:0] OFF_CLR    = 6'h20;

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic       in_window;
  logic       ld;
  logic       st;
  logic [5:0] off;
  logic       rx_pop_req;
  logic       tx_push_req;
  logic       flags_clr;
  logic       cnt_clr;
  logic       unused_bits;

  assign in_window   = bus.addr[31:28] == 4'h8;
  assign ld          = bus.re && in_window;
  assign st          = bus.we && in_window;
  assign off         = bus.addr[5:0];
  // A combined load+store performs only the store, so the load must not pop.
  assign rx_pop_req  = ld && !st && (off == OFF_RX);
  assign tx_push_req = st && (off == OFF_TX);
  assign flags_clr   = st && (off == OFF_FLAGS);
  assign cnt_clr     = st && (off == OFF_CLR);
  assign unused_bits = ^{bus.addr[27:6], bus.wdata[31:8]};

  // ---------------------------------------------------------------------
  // RX FIFO (UART -> CPU)
  // ---------------------------------------------------------------------
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wr_ptr;
  logic [AW-1:0] rx_rd_ptr;
  logic [AW:0]   rx_count;
  logic          rx_full;
  logic          rx_empty;
  logic          rx_push;
  logic          rx_pop;

  assign rx_full  = rx_count == FULL_CNT;
  assign rx_empty = rx_count == '0;
  assign rx_ready = !rx_full;
  // A push while full is refused even if a pop frees a slot this cycle.
  assign rx_push  = rx_valid && !rx_full;
  assign rx_pop   = rx_pop_req && !rx_empty;

  // NOTE: the byte storage is deliberately not reset; occupancy and pointers
  // define what is valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, which is what makes reads see pre-update state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (rx_pop && !rx_push) rx_count <= rx_count - 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // TX FIFO (CPU -> UART)
  // ---------------------------------------------------------------------
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr;
  logic [AW-1:0] tx_rd_ptr;
  logic [AW:0]   tx_count;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_push;
  logic          tx_pop;

  assign tx_full  = tx_count == FULL_CNT;
  assign tx_empty = tx_count == '0;
  assign tx_valid = !tx_empty;
  // Gate the head so the unreset storage never leaks onto tx_data.
  assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];
  assign tx_push  = tx_push_req && !tx_full;
  assign tx_pop   = tx_ready && !tx_empty;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (tx_pop && !tx_push) tx_count <= tx_count - 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Sticky error flags: a set in the same cycle as a clear wins.
  // ---------------------------------------------------------------------
  logic tx_overflow;
  logic rx_underflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      tx_overflow  <= (tx_push_req && tx_full)  || (tx_overflow  && !flags_clr);
      rx_underflow <= (rx_pop_req  && rx_empty) || (rx_underflow && !flags_clr);
    end
  end

  // ---------------------------------------------------------------------
  // Performance counters: clear beats increment, all wrap naturally.
  // ---------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] cyc_cnt;
  logic [CNT_WIDTH-1:0] inst_cnt;
  logic [CNT_WIDTH-1:0] br_cnt;
  logic [CNT_WIDTH-1:0] brc_cnt;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
      br_cnt   <= '0;
      brc_cnt  <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (inst_retire)              inst_cnt <= inst_cnt + 1'b1;
      if (br_retire)                br_cnt   <= br_cnt + 1'b1;
      if (br_retire && br_correct)  brc_cnt  <= brc_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Read mux and registered load data
  // ---------------------------------------------------------------------
  logic [31:0] rd_val;

  // NOTE: rd_val gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_STATUS: rd_val = {8'h00, 8'(tx_count), 8'(rx_count), 6'h00,
                            !rx_empty, !tx_full};
      OFF_RX:     rd_val = rx_empty ? 32'h0 : 32'(rx_mem[rx_rd_ptr]);
      OFF_FLAGS:  rd_val = {30'h0, rx_underflow, tx_overflow};
      OFF_CYC:    rd_val = 32'(cyc_cnt);
      OFF_INST:   rd_val = 32'(inst_cnt);
      OFF_BR:     rd_val = 32'(br_cnt);
      OFF_BRC:    rd_val = 32'(brc_cnt);
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)     bus.rdata <= '0;
    else if (ld) bus.rdata <= st ? 32'h0 : rd_val;
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
`timescale 1ns/1ps
module tb_mmio_io_ctrl;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmio_io_ctrl_if bus ();
  mmio_io_ctrl_if bus4 ();

  logic       inst_retire, br_retire, br_correct;
  logic [7:0] rx_data, tx_data, tx_data4;
  logic       rx_valid, rx_ready, tx_valid, tx_ready, rx_ready4, tx_valid4;

  mmio_io_ctrl #(.DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .inst_retire(inst_retire), .br_retire(br_retire), .br_correct(br_correct),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  // Narrow-counter instance used only for the wrap check.
  mmio_io_ctrl #(.DEPTH(DEPTH), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .inst_retire(1'b0), .br_retire(1'b0), .br_correct(1'b0),
    .rx_data(8'h00), .rx_valid(1'b0), .rx_ready(rx_ready4),
    .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(1'b0)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  logic        m_ovf, m_unf;
  logic [31:0] m_cyc, m_ins, m_br, m_brc, m_rdata;
  logic [3:0]  m4_cyc;
  logic [31:0] m4_rdata;

  // Called once per rising edge with the inputs that edge samples.
  task automatic model_step();
    logic       ld, st, set_ovf, set_unf;
    logic [5:0] off;
    logic [31:0] v;
    int rxn, txn;
    if (rst) begin
      rx_q.delete(); tx_q.delete();
      m_ovf = 0; m_unf = 0;
      m_cyc = 0; m_ins = 0; m_br = 0; m_brc = 0; m_rdata = 0;
      m4_cyc = 0; m4_rdata = 0;
      return;
    end
    ld  = bus.re && (bus.addr[31:28] == 4'h8);
    st  = bus.we && (bus.addr[31:28] == 4'h8);
    off = bus.addr[5:0];
    rxn = rx_q.size();
    txn = tx_q.size();
    v = 0;
    if (ld && !st) begin
      case (off)
        6'h00: v = (txn << 16) | (rxn << 8) | ((rxn != 0) ? 2 : 0) | ((txn != DEPTH) ? 1 : 0);
        6'h04: v = (rxn != 0) ? 32'(rx_q[0]) : 32'h0;
        6'h0C: v = (m_unf ? 2 : 0) | (m_ovf ? 1 : 0);
        6'h10: v = m_cyc;
        6'h14: v = m_ins;
        6'h18: v = m_br;
        6'h1C: v = m_brc;
        default: v = 0;
      endcase
    end
    if (ld) m_rdata = v;
    set_unf = ld && !st && off == 6'h04 && rxn == 0;
    if (ld && !st && off == 6'h04 && rxn != 0) void'(rx_q.pop_front());
    if (rx_valid && rxn < DEPTH) rx_q.push_back(rx_data);
    if (txn != 0 && tx_ready) void'(tx_q.pop_front());
    set_ovf = st && off == 6'h08 && txn == DEPTH;
    if (st && off == 6'h08 && txn < DEPTH) tx_q.push_back(bus.wdata[7:0]);
    if (st && off == 6'h0C) begin m_ovf = 0; m_unf = 0; end
    m_ovf = m_ovf | set_ovf;
    m_unf = m_unf | set_unf;
    if (st && off == 6'h20) begin
      m_cyc = 0; m_ins = 0; m_br = 0; m_brc = 0;
    end else begin
      m_cyc = m_cyc + 1;
      if (inst_retire) m_ins = m_ins + 1;
      if (br_retire) m_br = m_br + 1;
      if (br_retire && br_correct) m_brc = m_brc + 1;
    end
    // bus4 only ever issues loads of the cycle counter.
    if (bus4.re && bus4.addr[31:28] == 4'h8)
      m4_rdata = (bus4.addr[5:0] == 6'h10) ? 32'(m4_cyc) : 32'h0;
    m4_cyc = m4_cyc + 1'b1;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("tx_valid", 32'(tx_valid), 32'(tx_q.size() != 0));
      check("tx_data", 32'(tx_data), (tx_q.size() != 0) ? 32'(tx_q[0]) : 32'h0);
      check("rx_ready", 32'(rx_ready), 32'(rx_q.size() < DEPTH));
      check("rdata", bus.rdata, m_rdata);
      check("rdata4", bus4.rdata, m4_rdata);
    end
  end

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic load(input logic [5:0] off);
    bus.addr = BASE | 32'(off); bus.re = 1'b1;
    cycle();
    bus.re = 1'b0;
  endtask

  task automatic load_chk(input logic [5:0] off, input string name, input logic [31:0] exp);
    load(off);
    check(name, bus.rdata, exp);
  endtask

  task automatic store(input logic [5:0] off, input logic [31:0] d);
    bus.addr = BASE | 32'(off); bus.wdata = d; bus.we = 1'b1;
    cycle();
    bus.we = 1'b0;
  endtask

  task automatic load4_chk(input string name, input logic [31:0] exp);
    bus4.addr = BASE | 32'h10; bus4.re = 1'b1;
    cycle();
    bus4.re = 1'b0;
    check(name, bus4.rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got[$];
    rst = 1'b1;
    bus.addr = 0;  bus.re = 0;  bus.we = 0;  bus.wdata = 0;
    bus4.addr = 0; bus4.re = 0; bus4.we = 0; bus4.wdata = 0;
    inst_retire = 0; br_retire = 0; br_correct = 0;
    rx_data = 0; rx_valid = 0; tx_ready = 0;
    cycle();
    rst = 1'b0;
    cmp_en = 1'b1;

    // Reset state
    check("reset tx_valid", 32'(tx_valid), 0);
    check("reset rx_ready", 32'(rx_ready), 1);
    check("reset tx_data", 32'(tx_data), 0);
    check("reset rdata", bus.rdata, 0);
    load_chk(6'h00, "reset status", 32'h0000_0001);
    load_chk(6'h0C, "reset flags", 0);

    // TX fill, overflow, ordered drain
    for (int i = 0; i < 9; i++) store(6'h08, 32'h41 + i);
    load_chk(6'h00, "tx full status", 32'h0008_0000);
    load_chk(6'h0C, "tx overflow flag", 32'h1);
    tx_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (tx_valid) got.push_back(tx_data);
      cycle();
    end
    tx_ready = 1'b0;
    check("tx drain count", got.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < got.size()) check("tx drain byte", 32'(got[i]), 32'h41 + i);
    store(6'h0C, 32'hFFFF_FFFF);
    load_chk(6'h0C, "flags cleared", 0);

    // RX fill, refused push while full with pop, drain, underflow
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'(8'h10 + i);
      cycle();
    end
    check("rx full rx_ready", 32'(rx_ready), 0);
    rx_data = 8'h99;
    load_chk(6'h04, "rx pop while full", 32'h10);
    rx_valid = 1'b0;
    for (int i = 1; i < 8; i++) load_chk(6'h04, "rx pop", 32'h10 + i);
    load_chk(6'h04, "rx underflow data", 0);
    load_chk(6'h0C, "rx underflow flag", 32'h2);
    store(6'h0C, 0);

    // RX steady at 3 with simultaneous push/pop across pointer wrap
    rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'(8'h20 + i);
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      rx_data = 8'(8'h23 + i);
      load_chk(6'h04, "rx steady pop", 32'h20 + i);
    end
    rx_valid = 1'b0;
    load_chk(6'h00, "rx steady status", 32'h0000_0303);
    for (int i = 0; i < 3; i++) load_chk(6'h04, "rx drain", 32'h2A + i);

    // Load and store together: store happens, rdata is 0
    bus.addr = BASE | 32'h08; bus.wdata = 32'h5A; bus.re = 1'b1; bus.we = 1'b1;
    cycle();
    bus.re = 1'b0; bus.we = 1'b0;
    check("re+we rdata", bus.rdata, 0);
    check("re+we tx_data", 32'(tx_data), 32'h5A);
    tx_ready = 1'b1;
    cycle();
    bus.addr = 32'h1000_0008; bus.wdata = 32'h77; bus.we = 1'b1;
    cycle();
    bus.we = 1'b0; tx_ready = 1'b0;
    check("out-of-window store", 32'(tx_valid), 0);

    // Counters
    store(6'h20, 0);
    for (int i = 0; i < 10; i++) begin
      inst_retire = 1'b1;
      br_retire   = (i == 1 || i == 3 || i == 5 || i == 7);
      br_correct  = (i == 1 || i == 2 || i == 3 || i == 7);
      cycle();
    end
    inst_retire = 0; br_retire = 0; br_correct = 0;
    load_chk(6'h14, "inst count", 32'd10);
    load_chk(6'h18, "branch count", 32'd4);
    load_chk(6'h1C, "correct count", 32'd3);
    inst_retire = 1'b1;
    store(6'h20, 0);
    inst_retire = 1'b0;
    load_chk(6'h14, "inst after clear", 0);

    // Reset mid-stream
    load(6'h04);
    for (int i = 0; i < 5; i++) store(6'h08, 32'h60 + i);
    rx_valid = 1'b1; rx_data = 8'hC3;
    rst = 1'b1;
    cycle();
    rst = 1'b0; rx_valid = 1'b0;
    check("mid reset tx_valid", 32'(tx_valid), 0);
    load_chk(6'h00, "mid reset status", 32'h0000_0001);
    load_chk(6'h0C, "mid reset flags", 0);
    store(6'h08, 32'hB7);
    check("restart tx_data", 32'(tx_data), 32'hB7);

    // 4-bit cycle counter wraps 15 -> 0
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (15) cycle();
    load4_chk("cnt4 at 15", 32'd15);
    load4_chk("cnt4 wrapped", 32'd0);

    cycle();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
